// File: rtl/flash_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | flash_ctrl_pkg : shared types and defaults for the SPI flash reader   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package flash_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        A2    = 3'd2,
        A1    = 3'd3,
        A0    = 3'd4,
        DATA  = 3'd5,
        FLUSH = 3'd6,
        DESEL = 3'd7
    } state_t;

    localparam logic [7:0] CMD_READ_DEF = 8'h03;
    localparam int         XFER_GAP_DEF = 18;
    localparam int         CS_HIGH_DEF  = 4;
    // Engine updates its result register on the falling edge after a strobe.
    localparam int         CAP_OFFSET   = 2;

endpackage
`default_nettype wire

// File: rtl/spi_xfer_pacer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_xfer_pacer : strobe spacing counter and result-capture timing     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module spi_xfer_pacer
    import flash_ctrl_pkg::*;
#(
    parameter int XFER_GAP = XFER_GAP_DEF,
    parameter int CAP_DLY  = CAP_OFFSET
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic strobe,
    output logic strobe_ok,
    output logic capture
);

    localparam logic [4:0] GAP_LOAD = 5'(XFER_GAP - 1);
    localparam logic [4:0] CAP_VAL  = 5'(XFER_GAP - CAP_DLY);

    logic [4:0] r_gap;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= 5'd0;
        end else if (strobe) begin
            r_gap <= GAP_LOAD;
        end else if (r_gap != 5'd0) begin
            r_gap <= r_gap - 5'd1;
        end
    end

    // The count passes CAP_VAL exactly once per strobe, CAP_DLY cycles after it.
    assign strobe_ok = (r_gap == 5'd0);
    assign capture   = (r_gap == CAP_VAL);

endmodule
`default_nettype wire

// File: rtl/spi_flash_read_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_flash_read_ctrl : issues flash READ and streams len bytes out     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module spi_flash_read_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter logic [7:0] CMD_READ = CMD_READ_DEF,
    parameter int         XFER_GAP = XFER_GAP_DEF,
    parameter int         CS_HIGH  = CS_HIGH_DEF
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        req,
    input  logic [23:0] addr,
    input  logic [15:0] len,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        spi_tx,
    output logic        spi_rx,
    output logic [7:0]  spi_din,
    input  logic [7:0]  spi_dout,
    output logic        spi_cs_n
);

    localparam logic [7:0] HOLD_LAST = 8'(CS_HIGH - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_addr;
    logic [15:0] r_rem;
    logic        r_data_seen;
    logic        r_arm;
    logic        r_released;
    logic [7:0]  r_hold;
    logic        w_strobe_ok;
    logic        w_capture;
    logic        w_strobe;
    logic        w_accept;

    assign w_accept = (r_state == IDLE) && req;
    assign w_strobe = spi_tx | spi_rx;

    spi_xfer_pacer #(
        .XFER_GAP (XFER_GAP),
        .CAP_DLY  (CAP_OFFSET)
    ) u_pacer (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .strobe    (w_strobe),
        .strobe_ok (w_strobe_ok),
        .capture   (w_capture)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req)         w_state_nxt = CMD;
            CMD:     if (w_strobe_ok) w_state_nxt = A2;
            A2:      if (w_strobe_ok) w_state_nxt = A1;
            A1:      if (w_strobe_ok) w_state_nxt = A0;
            A0:      if (w_strobe_ok) w_state_nxt = (r_rem == 16'd0) ? DESEL : DATA;
            DATA:    if (w_strobe_ok && r_rem == 16'd1) w_state_nxt = FLUSH;
            FLUSH:   if (w_strobe_ok) w_state_nxt = DESEL;
            DESEL:   if (r_released && r_hold >= HOLD_LAST) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        spi_tx   = 1'b0;
        spi_rx   = 1'b0;
        spi_din  = 8'h00;
        done     = 1'b0;
        busy     = (r_state != IDLE);
        spi_cs_n = 1'b0;
        case (r_state)
            IDLE:  spi_cs_n = 1'b1;
            CMD:   begin spi_tx = w_strobe_ok; spi_din = CMD_READ;       end
            A2:    begin spi_tx = w_strobe_ok; spi_din = r_addr[23:16];  end
            A1:    begin spi_tx = w_strobe_ok; spi_din = r_addr[15:8];   end
            A0:    begin spi_tx = w_strobe_ok; spi_din = r_addr[7:0];    end
            DATA:  spi_rx = w_strobe_ok;
            FLUSH: spi_rx = w_strobe_ok;
            DESEL: begin
                // Deselect only once the final transfer has had its full gap.
                done     = !r_released && w_strobe_ok;
                spi_cs_n = r_released || w_strobe_ok;
            end
            default: spi_cs_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= 24'd0;
            r_rem       <= 16'd0;
            r_data_seen <= 1'b0;
            r_arm       <= 1'b0;
            r_released  <= 1'b0;
            r_hold      <= 8'd0;
            rd_valid    <= 1'b0;
            rd_data     <= 8'h00;
        end else begin
            if (w_accept) begin
                r_addr      <= addr;
                r_rem       <= len;
                r_data_seen <= 1'b0;
                r_arm       <= 1'b0;
                r_released  <= 1'b0;
                r_hold      <= 8'd0;
            end
            if (spi_rx) begin
                r_data_seen <= 1'b1;
                if (r_state == DATA) begin
                    r_rem <= r_rem - 16'd1;
                end
            end
            // A read strobe returns the previous read's byte; the first one returns A0's.
            if (w_strobe) begin
                r_arm <= spi_rx & r_data_seen;
            end
            if (done) begin
                r_released <= 1'b1;
                r_hold     <= 8'd1;
            end else if (r_released && r_state == DESEL) begin
                r_hold <= r_hold + 8'd1;
            end
            rd_valid <= w_capture & r_arm;
            if (w_capture & r_arm) begin
                rd_data <= spi_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_read_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_spi_flash_read_ctrl : DUT + byte engine + READ-only flash model    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_spi_flash_read_ctrl;

    localparam int GAP = 18;
    localparam int CSH = 4;

    logic        clk_sys = 1'b0;
    logic        rst_n   = 1'b1;
    logic        req     = 1'b0;
    logic [23:0] addr    = 24'd0;
    logic [15:0] len     = 16'd0;
    logic        busy, done, rd_valid, spi_tx, spi_rx, spi_cs_n;
    logic [7:0]  rd_data, spi_din;
    logic [7:0]  eng_dout    = 8'h00;
    logic [7:0]  eng_pending = 8'hFF;

    spi_flash_read_ctrl dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .req      (req),
        .addr     (addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .spi_tx   (spi_tx),
        .spi_rx   (spi_rx),
        .spi_din  (spi_din),
        .spi_dout (eng_dout),
        .spi_cs_n (spi_cs_n)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor-owned statistics
    int cyc = 0;
    int rv_cnt = 0, tx_cnt = 0, rx_cnt = 0, done_cnt = 0, done_cyc = 0;
    int gap_viol = 0, co_cnt = 0, mism = 0, extra = 0, cs_short = 0;
    int cs_run = 0, last_cyc = 0, fl_idx = 0;
    bit last_valid = 1'b0, fl_ok = 1'b0;
    logic [23:0] fl_addr = 24'd0;
    logic [7:0]  mosi_q[$];

    // Expectation of the current request, owned by the stimulus process
    logic [23:0] exp_addr = 24'd0;
    int          exp_len  = 0;
    int          exp_base = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin : mon
        logic [7:0]  mosi, miso, exp_b;
        logic [23:0] ea;
        int          k;
        if (spi_cs_n) begin
            fl_idx = 0;
            last_valid = 1'b0;
            cs_run++;
        end else begin
            if (cs_run > 0 && cs_run < CSH) cs_short++;
            cs_run = 0;
        end
        if (spi_tx && spi_rx) co_cnt++;
        if (spi_tx || spi_rx) begin
            mosi = spi_tx ? spi_din : 8'hFF;
            miso = 8'hFF;
            if (spi_tx) begin
                tx_cnt++;
                mosi_q.push_back(spi_din);
            end else begin
                rx_cnt++;
            end
            if (last_valid && (cyc - last_cyc) != GAP) gap_viol++;
            last_cyc   = cyc;
            last_valid = 1'b1;
            if (!spi_cs_n) begin
                if (fl_idx == 0)      fl_ok = (mosi == 8'h03);
                else if (fl_idx < 4)  fl_addr = {fl_addr[15:0], mosi};
                else if (fl_ok) begin
                    miso    = fl_addr[7:0] ^ 8'h5A;
                    fl_addr = fl_addr + 24'd1;
                end
                fl_idx++;
            end
            eng_dout    <= eng_pending;
            eng_pending <= miso;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rd_valid) begin
            k = rv_cnt - exp_base;
            ea = exp_addr + 24'(k);
            exp_b = ea[7:0] ^ 8'h5A;
            if (k >= exp_len) begin
                extra++;
            end else if (rd_data !== exp_b) begin
                mism++;
                $display("note: byte %0d of read at %h: got %h, expected %h", k, exp_addr, rd_data, exp_b);
            end
            rv_cnt++;
        end
    end

    task automatic do_req(input logic [23:0] a, input int l, input bit poke);
        int b_rv, b_tx, b_rx, b_done, b_gap, b_co, b_mism, b_extra, b_cs, mb, nstr, req_cyc, n;
        n = 0;
        while (busy && n < 20000) begin @(negedge clk_sys); n++; end
        b_rv = rv_cnt; b_tx = tx_cnt; b_rx = rx_cnt; b_done = done_cnt; b_gap = gap_viol;
        b_co = co_cnt; b_mism = mism; b_extra = extra; b_cs = cs_short; mb = mosi_q.size();
        exp_addr = a; exp_len = l; exp_base = rv_cnt;
        req = 1'b1; addr = a; len = 16'(l); req_cyc = cyc;
        @(negedge clk_sys);
        req = 1'b0; addr = 24'($urandom); len = 16'($urandom);
        check("busy_after_req", busy, 1);
        if (poke) begin
            repeat (40) @(negedge clk_sys);
            req = 1'b1; addr = ~a; len = 16'd3;
            @(negedge clk_sys);
            req = 1'b0;
        end
        nstr = 4 + l + ((l > 0) ? 1 : 0);
        n = 0;
        while (busy && n < GAP * nstr + 100) begin @(negedge clk_sys); n++; end
        check("busy_end", busy, 0);
        check("cs_n_end", spi_cs_n, 1);
        check("done_pulses", done_cnt - b_done, 1);
        check("done_latency", done_cyc - req_cyc, 1 + GAP * nstr);
        check("tx_strobes", tx_cnt - b_tx, 4);
        check("rx_strobes", rx_cnt - b_rx, l + ((l > 0) ? 1 : 0));
        check("rd_valid_count", rv_cnt - b_rv, l);
        check("rd_data_bad", mism - b_mism, 0);
        check("rd_extra", extra - b_extra, 0);
        check("strobe_gap_bad", gap_viol - b_gap, 0);
        check("tx_rx_overlap", co_cnt - b_co, 0);
        check("cs_high_short", cs_short - b_cs, 0);
        if (mosi_q.size() >= mb + 4)
            check("mosi_hdr", {mosi_q[mb], mosi_q[mb+1], mosi_q[mb+2], mosi_q[mb+3]}, {8'h03, a});
        else
            check("mosi_count", mosi_q.size() - mb, 4);
    endtask

    initial begin : stim
        int          b, n;
        logic [23:0] a;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_spi_tx", spi_tx, 0);
        check("rst_spi_rx", spi_rx, 0);
        check("rst_spi_din", spi_din, 0);
        check("rst_cs_n", spi_cs_n, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        do_req(24'h012345, 4, 1'b0);
        do_req(24'($urandom), 0, 1'b0);
        do_req(24'($urandom), 8, 1'b1);
        do_req(24'($urandom), 300, 1'b0);

        // Reset in the middle of the data phase
        a = 24'($urandom);
        b = rv_cnt;
        exp_addr = a; exp_len = 10; exp_base = rv_cnt;
        req = 1'b1; addr = a; len = 16'd10;
        @(negedge clk_sys);
        req = 1'b0;
        n = 0;
        while ((rv_cnt - b) < 2 && n < 1000) begin @(negedge clk_sys); n++; end
        check("rst_pre_bytes", rv_cnt - b, 2);
        repeat (6) @(negedge clk_sys);
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", spi_cs_n, 1);
        check("midrst_busy", busy, 0);
        check("midrst_rd_valid", rd_valid, 0);
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        repeat (60) @(negedge clk_sys);
        check("midrst_no_more_bytes", rv_cnt - b, 2);
        do_req(24'($urandom), 5, 1'b0);

        // Back-to-back, including address wrap in the flash
        do_req(24'hFFFFFF, 2, 1'b0);
        do_req(24'($urandom), 3, 1'b0);

        for (int i = 0; i < 6; i++)
            do_req(24'($urandom), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
